// File: rtl/vc_arbiter_pkg.sv
// Shared widths and encodings for the two-VC weighted arbiter and its routing stage.
package vc_arbiter_pkg;

  localparam int unsigned DATA_WIDTH  = 6;
  localparam int unsigned DEST_BIT    = 4;
  localparam int unsigned WEIGHT      = 3;
  localparam int unsigned CNT_WIDTH   = 8;
  localparam int unsigned BURST_WIDTH = 4;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;
  localparam logic SRC_VC0 = 1'b0;
  localparam logic SRC_VC1 = 1'b1;

endpackage

// File: rtl/vc_route_stage.sv
// Second pipeline stage: selects the returned FIFO word, decodes its destination,
// registers the destination push/data and counts forwarded words per source VC.
module vc_route_stage
  import vc_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned dest_bit   = DEST_BIT,
  parameter int unsigned cnt_width  = CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vld,
  input  logic                  sel,
  input  logic [data_width-1:0] vc0_data,
  input  logic [data_width-1:0] vc1_data,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [data_width-1:0] d0_data,
  output logic [data_width-1:0] d1_data,
  output logic [cnt_width-1:0]  vc0_fwd_cnt,
  output logic [cnt_width-1:0]  vc1_fwd_cnt
);

  logic                  d0_push_q, d0_push_d;
  logic                  d1_push_q, d1_push_d;
  logic [data_width-1:0] d0_data_q, d0_data_d;
  logic [data_width-1:0] d1_data_q, d1_data_d;
  logic [cnt_width-1:0]  vc0_cnt_q, vc0_cnt_d;
  logic [cnt_width-1:0]  vc1_cnt_q, vc1_cnt_d;
  logic [data_width-1:0] word_c;

  always_comb begin
    word_c    = (sel == SRC_VC1) ? vc1_data : vc0_data;
    d0_push_d = 1'b0;
    d1_push_d = 1'b0;
    d0_data_d = d0_data_q;
    d1_data_d = d1_data_q;
    vc0_cnt_d = vc0_cnt_q;
    vc1_cnt_d = vc1_cnt_q;
    if (!init) begin
      // In-flight word is dropped and every output returns to its cleared value
      d0_data_d = '0;
      d1_data_d = '0;
      vc0_cnt_d = '0;
      vc1_cnt_d = '0;
    end else if (vld) begin
      if (word_c[dest_bit] == DEST_D1) begin
        d1_push_d = 1'b1;
        d1_data_d = word_c;
      end else begin
        d0_push_d = 1'b1;
        d0_data_d = word_c;
      end
      if (sel == SRC_VC1) vc1_cnt_d = vc1_cnt_q + 1'b1;
      else                vc0_cnt_d = vc0_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      d0_data_q <= '0;
      d1_data_q <= '0;
      vc0_cnt_q <= '0;
      vc1_cnt_q <= '0;
    end else begin
      d0_push_q <= d0_push_d;
      d1_push_q <= d1_push_d;
      d0_data_q <= d0_data_d;
      d1_data_q <= d1_data_d;
      vc0_cnt_q <= vc0_cnt_d;
      vc1_cnt_q <= vc1_cnt_d;
    end
  end

  assign d0_push     = d0_push_q;
  assign d1_push     = d1_push_q;
  assign d0_data     = d0_data_q;
  assign d1_data     = d1_data_q;
  assign vc0_fwd_cnt = vc0_cnt_q;
  assign vc1_fwd_cnt = vc1_cnt_q;

endmodule

// File: rtl/vc_arbiter.sv
// Weighted two-VC pop arbiter: VC0 favoured, VC1 served after `weight` back-to-back
// VC0 grants; popped words are routed to D0/D1 two cycles later.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned dest_bit   = DEST_BIT,
  parameter int unsigned weight     = WEIGHT,
  parameter int unsigned cnt_width  = CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [data_width-1:0] vc0_data,
  input  logic [data_width-1:0] vc1_data,
  output logic                  vc0_pop,
  output logic                  vc1_pop,
  input  logic                  d0_almost_full,
  input  logic                  d1_almost_full,
  output logic                  d0_push,
  output logic                  d1_push,
  output logic [data_width-1:0] d0_data,
  output logic [data_width-1:0] d1_data,
  output logic                  arb_idle,
  output logic [cnt_width-1:0]  vc0_fwd_cnt,
  output logic [cnt_width-1:0]  vc1_fwd_cnt
);

  logic                   stall_c;
  logic [BURST_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic                   sel_q, sel_d;
  logic                   vld_q, vld_d;

  assign stall_c = d0_almost_full | d1_almost_full;

  // Grant decision; reset also kills pops so nothing leaves a FIFO while held
  always_comb begin
    vc0_pop = 1'b0;
    vc1_pop = 1'b0;
    if (!reset && init && !stall_c && !(vc0_empty && vc1_empty)) begin
      if (vc1_empty)                                  vc0_pop = 1'b1;
      else if (vc0_empty)                             vc1_pop = 1'b1;
      else if (burst_cnt_q == BURST_WIDTH'(weight))   vc1_pop = 1'b1;
      else                                            vc0_pop = 1'b1;
    end
  end

  // Consecutive VC0 grants while VC1 waits; held across stalls
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!init || vc1_pop) begin
      burst_cnt_d = '0;
    end else if (vc0_pop && !vc1_empty) begin
      if (burst_cnt_q < BURST_WIDTH'(weight)) burst_cnt_d = burst_cnt_q + 1'b1;
    end else if (vc1_empty && !vc0_pop) begin
      burst_cnt_d = '0;
    end
  end

  always_comb begin
    vld_d = vc0_pop | vc1_pop;
    sel_d = vc1_pop ? SRC_VC1 : SRC_VC0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt_q <= '0;
      sel_q       <= SRC_VC0;
      vld_q       <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      sel_q       <= sel_d;
      vld_q       <= vld_d;
    end
  end

  vc_route_stage #(
    .data_width (data_width),
    .dest_bit   (dest_bit),
    .cnt_width  (cnt_width)
  ) u_route (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .vld         (vld_q),
    .sel         (sel_q),
    .vc0_data    (vc0_data),
    .vc1_data    (vc1_data),
    .d0_push     (d0_push),
    .d1_push     (d1_push),
    .d0_data     (d0_data),
    .d1_data     (d1_data),
    .vc0_fwd_cnt (vc0_fwd_cnt),
    .vc1_fwd_cnt (vc1_fwd_cnt)
  );

  assign arb_idle = reset | (~vld_q & ~d0_push & ~d1_push & vc0_empty & vc1_empty);

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: queue-based VC FIFO models plus a transaction-level
// reference of grant order, routing and counters.
module tb_vc_arbiter;
  import vc_arbiter_pkg::*;

  localparam int unsigned DW = 6;
  localparam int unsigned DB = 4;
  localparam int unsigned W  = 3;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset, init;
  logic          vc0_empty, vc1_empty;
  logic [DW-1:0] vc0_data, vc1_data;
  logic          vc0_pop, vc1_pop;
  logic          d0_almost_full, d1_almost_full;
  logic          d0_push, d1_push;
  logic [DW-1:0] d0_data, d1_data;
  logic          arb_idle;
  logic [CW-1:0] vc0_fwd_cnt, vc1_fwd_cnt;

  vc_arbiter #(.data_width(DW), .dest_bit(DB), .weight(W), .cnt_width(CW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .d0_push(d0_push), .d1_push(d1_push),
    .d0_data(d0_data), .d1_data(d1_data),
    .arb_idle(arb_idle),
    .vc0_fwd_cnt(vc0_fwd_cnt), .vc1_fwd_cnt(vc1_fwd_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  bit g_init, g_af0, g_af1, cur_init;

  // Reference state: one word in flight between grant and push
  bit            m_vld, m_src;
  logic [DW-1:0] m_word;
  bit            e_p0, e_p1;
  logic [DW-1:0] e_d0, e_d1;
  logic [CW-1:0] e_c0, e_c1;
  int            streak, streak_n;
  bit            x_pop0, x_pop1;
  int            n_push;
  logic [7:0]    ord;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_vld = 0; m_src = 0; m_word = '0;
    e_p0 = 0; e_p1 = 0; e_d0 = '0; e_d1 = '0; e_c0 = '0; e_c1 = '0;
    streak = 0; streak_n = 0; x_pop0 = 0; x_pop1 = 0;
  endtask

  // Expected grant for the current cycle from FIFO occupancy and the VC0 streak
  task automatic decide();
    bool_e: begin end
    x_pop0 = 0; x_pop1 = 0;
    if (!reset && g_init && !(g_af0 || g_af1) && (q0.size() != 0 || q1.size() != 0)) begin
      if (q1.size() == 0)      x_pop0 = 1;
      else if (q0.size() == 0) x_pop1 = 1;
      else if (streak == W)    x_pop1 = 1;
      else                     x_pop0 = 1;
    end
    streak_n = streak;
    if (!g_init || x_pop1) streak_n = 0;
    else if (x_pop0 && q1.size() != 0) streak_n = (streak < W) ? streak + 1 : streak;
    else if (q1.size() == 0 && !x_pop0) streak_n = 0;
  endtask

  task automatic check_outputs();
    logic exp_idle;
    exp_idle = reset | (!m_vld && !e_p0 && !e_p1 && q0.size() == 0 && q1.size() == 0);
    chk("vc0_pop", 32'(vc0_pop), 32'(x_pop0));
    chk("vc1_pop", 32'(vc1_pop), 32'(x_pop1));
    chk("d0_push", 32'(d0_push), 32'(e_p0));
    chk("d1_push", 32'(d1_push), 32'(e_p1));
    chk("d0_data", 32'(d0_data), 32'(e_d0));
    chk("d1_data", 32'(d1_data), 32'(e_d1));
    chk("vc0_fwd_cnt", 32'(vc0_fwd_cnt), 32'(e_c0));
    chk("vc1_fwd_cnt", 32'(vc1_fwd_cnt), 32'(e_c1));
    chk("arb_idle", 32'(arb_idle), 32'(exp_idle));
  endtask

  // One clock: advance the reference over the edge, apply this cycle's inputs, compare
  task automatic step();
    @(posedge clk);
    #1;
    if (reset || !cur_init) begin
      model_clear();
    end else begin
      e_p0 = m_vld && (m_word[DB] == DEST_D0);
      e_p1 = m_vld && (m_word[DB] == DEST_D1);
      if (e_p0) e_d0 = m_word;
      if (e_p1) e_d1 = m_word;
      if (m_vld) begin
        if (m_src) e_c1 = e_c1 + 1'b1;
        else       e_c0 = e_c0 + 1'b1;
      end
      m_vld = x_pop0 | x_pop1;
      m_src = x_pop1;
      if (x_pop0) begin m_word = q0.pop_front(); vc0_data = m_word; end
      if (x_pop1) begin m_word = q1.pop_front(); vc1_data = m_word; end
      streak = streak_n;
    end
    init = g_init; cur_init = g_init;
    d0_almost_full = g_af0; d1_almost_full = g_af1;
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    decide();
    #1;
    check_outputs();
    n_push += int'(d0_push) + int'(d1_push);
  endtask

  initial begin
    reset = 1; init = 0; cur_init = 0;
    g_init = 0; g_af0 = 0; g_af1 = 0;
    vc0_empty = 1; vc1_empty = 1; vc0_data = '0; vc1_data = '0;
    d0_almost_full = 0; d1_almost_full = 0;
    model_clear();
    n_push = 0;
    repeat (3) step();
    reset = 0; decide(); #1;
    g_init = 1;
    repeat (2) step();

    // Single word from VC0 with destination bit set goes to D1
    q0.push_back(6'b010101);
    step();
    chk("single_pop", 32'(vc0_pop), 32'd1);
    repeat (2) step();
    chk("single_d1_push", 32'(d1_push), 32'd1);
    chk("single_d1_data", 32'(d1_data), 32'h15);
    chk("single_cnt", 32'(vc0_fwd_cnt), 32'd1);
    repeat (2) step();

    // Reset asserted mid-cycle while VC0 streams
    for (int i = 0; i < 4; i++) q0.push_back(6'($urandom));
    repeat (3) step();
    reset = 1; #1;
    chk("rst_pop0", 32'(vc0_pop), 32'd0);
    chk("rst_push", 32'({d0_push, d1_push}), 32'd0);
    chk("rst_cnt0", 32'(vc0_fwd_cnt), 32'd0);
    chk("rst_idle", 32'(arb_idle), 32'd1);
    model_clear();
    repeat (2) step();
    reset = 0; decide(); #1;
    repeat (4) step();

    // Weighted order with both VCs backlogged
    for (int i = 0; i < 8; i++) begin
      q0.push_back(6'($urandom));
      q1.push_back(6'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      step();
      ord[i] = vc1_pop;
    end
    chk("weighted_order", 32'(ord), 32'h88);
    repeat (12) step();

    // Destination almost-full stalls pops; in-flight words still land
    for (int i = 0; i < 12; i++) q0.push_back(6'($urandom));
    repeat (3) step();
    g_af0 = 1; n_push = 0;
    repeat (4) step();
    chk("stall_push_bound", 32'(n_push <= 2), 32'd1);
    g_af0 = 0;
    step();
    chk("stall_resume", 32'(vc0_pop), 32'd1);
    repeat (14) step();

    // init low discards in-flight words
    for (int i = 0; i < 6; i++) q0.push_back(6'($urandom));
    repeat (2) step();
    g_init = 0;
    step();
    n_push = 0;
    repeat (3) step();
    chk("init_no_push", 32'(n_push), 32'd0);
    g_init = 1;
    step();
    chk("init_restart", 32'(vc0_pop), 32'd1);
    repeat (10) step();

    // 256 words from VC1 wrap its counter
    g_init = 0; step(); g_init = 1; step();
    for (int i = 0; i < 256; i++) q1.push_back(6'($urandom));
    repeat (259) step();
    chk("wrap_cnt", 32'(vc1_fwd_cnt), 32'd0);
    chk("wrap_idle", 32'(arb_idle), 32'd1);

    // Random traffic, stalls and init drops
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2) == 0 && q0.size() < 16) q0.push_back(6'($urandom));
      if ($urandom_range(2) == 0 && q1.size() < 16) q1.push_back(6'($urandom));
      g_af0  = ($urandom_range(7) == 0);
      g_af1  = ($urandom_range(7) == 0);
      g_init = ($urandom_range(24) != 0);
      step();
    end
    g_af0 = 0; g_af1 = 0; g_init = 1;
    repeat (40) step();
    chk("final_idle", 32'(arb_idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
